// File: rtl/seg_scan_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_scan_decoder                                                          |
// | Rebuilds 8 hex digits + decimal points from scanned active-low SEG/AN.    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps

module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_in,
    input  logic [7:0]  an_in,
    output logic [31:0] digits,
    output logic [7:0]  dp,
    output logic        frame_valid,
    output logic        frame_stb,
    output logic        err_pattern,
    output logic        err_an
);

    localparam logic [7:0] c_STABLE  = 8'(STABLE_CYCLES);
    localparam logic [7:0] c_CAP_CNT = 8'(STABLE_CYCLES - 1);

    logic [15:0] sync1_q, sync_q, prev_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] shadow_q, shadow_d;
    logic [7:0]  shadow_dp_q, shadow_dp_d;
    logic [7:0]  seen_q, seen_d;
    logic [31:0] digits_q, digits_d;
    logic [7:0]  dp_q, dp_d;
    logic        valid_q, valid_d;
    logic        stb_q, stb_d;
    logic        err_pat_q, err_pat_d;
    logic        err_an_q, err_an_d;

    logic        w_capture;
    logic [7:0]  w_an_lo;
    logic        w_blank;
    logic        w_onehot;
    logic [2:0]  w_pos;
    logic        w_glyph_ok;
    logic [3:0]  w_nibble;

    assign w_capture = (cnt_q == c_CAP_CNT) && (sync_q == prev_q);
    assign w_an_lo   = ~sync_q[15:8];
    assign w_blank   = (w_an_lo == 8'd0);
    assign w_onehot  = !w_blank && ((w_an_lo & (w_an_lo - 8'd1)) == 8'd0);

    always_comb begin
        w_pos = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (w_an_lo[k]) begin
                w_pos = 3'(k);
            end
        end
    end

    always_comb begin
        w_glyph_ok = 1'b1;
        w_nibble   = 4'h0;
        case (sync_q[6:0])
            7'h40: w_nibble = 4'h0;
            7'h79: w_nibble = 4'h1;
            7'h24: w_nibble = 4'h2;
            7'h30: w_nibble = 4'h3;
            7'h19: w_nibble = 4'h4;
            7'h12: w_nibble = 4'h5;
            7'h02: w_nibble = 4'h6;
            7'h78: w_nibble = 4'h7;
            7'h00: w_nibble = 4'h8;
            7'h18: w_nibble = 4'h9;
            7'h08: w_nibble = 4'hA;
            7'h03: w_nibble = 4'hB;
            7'h46: w_nibble = 4'hC;
            7'h21: w_nibble = 4'hD;
            7'h06: w_nibble = 4'hE;
            7'h0E: w_nibble = 4'hF;
            default: w_glyph_ok = 1'b0;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        seen_d      = seen_q;
        digits_d    = digits_q;
        dp_d        = dp_q;
        valid_d     = valid_q;
        stb_d       = 1'b0;
        err_pat_d   = 1'b0;
        err_an_d    = 1'b0;

        if (sync_q != prev_q) begin
            cnt_d = 8'd1;
        end else if (cnt_q < c_STABLE) begin
            cnt_d = cnt_q + 8'd1;
        end

        // Publish first so a capture on the same edge starts the next frame's mask
        if (seen_q == 8'hFF) begin
            digits_d = shadow_q;
            dp_d     = shadow_dp_q;
            stb_d    = 1'b1;
            valid_d  = 1'b1;
            seen_d   = 8'h00;
        end

        if (w_capture) begin
            if (w_onehot) begin
                if (w_glyph_ok) begin
                    shadow_d[{w_pos, 2'b00} +: 4] = w_nibble;
                    shadow_dp_d[w_pos]            = ~sync_q[7];
                    seen_d[w_pos]                 = 1'b1;
                end else begin
                    err_pat_d = 1'b1;
                end
            end else if (!w_blank) begin
                err_an_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 16'hFFFF;
            sync_q      <= 16'hFFFF;
            prev_q      <= 16'hFFFF;
            cnt_q       <= 8'd0;
            shadow_q    <= 32'd0;
            shadow_dp_q <= 8'd0;
            seen_q      <= 8'd0;
            digits_q    <= 32'd0;
            dp_q        <= 8'd0;
            valid_q     <= 1'b0;
            stb_q       <= 1'b0;
            err_pat_q   <= 1'b0;
            err_an_q    <= 1'b0;
        end else begin
            sync1_q     <= {an_in, seg_in};
            sync_q      <= sync1_q;
            prev_q      <= sync_q;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            seen_q      <= seen_d;
            digits_q    <= digits_d;
            dp_q        <= dp_d;
            valid_q     <= valid_d;
            stb_q       <= stb_d;
            err_pat_q   <= err_pat_d;
            err_an_q    <= err_an_d;
        end
    end

    assign digits      = digits_q;
    assign dp          = dp_q;
    assign frame_valid = valid_q;
    assign frame_stb   = stb_q;
    assign err_pattern = err_pat_q;
    assign err_an      = err_an_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seg_scan_decoder                                                       |
// | Directed scans with an expected-frame queue checked on each frame_stb.    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps

module tb_seg_scan_decoder;

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  p;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg_in;
    logic [7:0]  an_in;
    logic [31:0] digits;
    logic [7:0]  dp;
    logic        frame_valid;
    logic        frame_stb;
    logic        err_pattern;
    logic        err_an;

    int checks = 0;
    int errors = 0;
    int n_stb = 0;
    int n_errp = 0;
    int n_erran = 0;
    frame_t exp_q[$];
    logic [6:0] glyph [16];

    seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .digits      (digits),
        .dp          (dp),
        .frame_valid (frame_valid),
        .frame_stb   (frame_stb),
        .err_pattern (err_pattern),
        .err_an      (err_an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pop the expected frame whenever the DUT publishes one
    always @(negedge clk) begin
        frame_t e;
        if (err_pattern === 1'b1) n_errp++;
        if (err_an === 1'b1) n_erran++;
        if (frame_stb === 1'b1) begin
            n_stb++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_frame_stb: observed digits %h dp %h expected no frame", digits, dp);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("frame_digits", 40'(digits), 40'(e.d));
                check("frame_dp", 40'(dp), 40'(e.p));
                check("frame_valid", 40'(frame_valid), 40'd1);
            end
        end
    end

    task automatic drive(input logic [7:0] an, input logic [7:0] seg, input int cyc);
        an_in  = an;
        seg_in = seg;
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic show(input int k, input int v, input logic dpon, input int cyc);
        drive(~(8'b1 << k), {~dpon, glyph[v]}, cyc);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check(tag, 40'(exp_q.size()), 40'd0);
    endtask

    initial begin
        glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst    = 1'b1;
        an_in  = 8'hFF;
        seg_in = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("reset_digits", 40'(digits), 40'd0);
        check("reset_dp", 40'(dp), 40'd0);
        check("reset_valid", 40'(frame_valid), 40'd0);
        check("reset_stb", 40'(frame_stb), 40'd0);
        check("reset_errp", 40'(err_pattern), 40'd0);
        check("reset_erran", 40'(err_an), 40'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Even digits in order
        exp_q.push_back('{d: 32'hECA86420, p: 8'h00});
        for (int k = 0; k < 8; k++) show(k, 2 * k, 1'b0, 10);
        drain("t1_drain");
        check("t1_stb_count", 40'(n_stb), 40'd1);

        // 1..8 with decimal point on digit 3
        exp_q.push_back('{d: 32'h87654321, p: 8'h08});
        for (int k = 0; k < 8; k++) show(k, k + 1, (k == 3), 10);
        drain("t2_drain");
        check("t2_stb_count", 40'(n_stb), 40'd2);

        // Short glitch inside digit 0's hold must be ignored
        exp_q.push_back('{d: 32'h76543210, p: 8'h00});
        drive(8'hFE, 8'hC0, 3);
        drive(8'hFE, 8'hF9, 3);
        drive(8'hFE, 8'hC0, 7);
        for (int k = 1; k < 8; k++) show(k, k, 1'b0, 10);
        drain("t3_drain");
        check("t3_stb_count", 40'(n_stb), 40'd3);
        check("t3_errp_count", 40'(n_errp), 40'd0);

        // All-off pattern on digit 2 blocks the frame until a legal glyph arrives
        drive(8'hFB, 8'hFF, 10);
        check("t4_errp_count", 40'(n_errp), 40'd1);
        for (int k = 0; k < 8; k++) if (k != 2) show(k, 15 - k, 1'b0, 10);
        check("t4_no_frame", 40'(n_stb), 40'd3);
        exp_q.push_back('{d: 32'h89ABCDEF, p: 8'h00});
        show(2, 13, 1'b0, 10);
        drain("t4_drain");
        check("t4_stb_count", 40'(n_stb), 40'd4);

        // Two selects low: error only, mask untouched
        for (int k = 1; k < 8; k++) show(k, k, 1'b0, 10);
        drive(8'hFC, 8'hC0, 10);
        check("t5_erran_count", 40'(n_erran), 40'd1);
        check("t5_no_frame", 40'(n_stb), 40'd4);
        exp_q.push_back('{d: 32'h76543210, p: 8'h00});
        show(0, 0, 1'b0, 10);
        drain("t5_drain");
        check("t5_stb_count", 40'(n_stb), 40'd5);

        // Reset mid-frame discards captured positions
        for (int k = 0; k < 5; k++) show(k, (k * 3) % 16, (k == 0), 10);
        drive(8'hFF, 8'hFF, 2);
        rst = 1'b1;
        #2;
        check("t6_rst_digits", 40'(digits), 40'd0);
        check("t6_rst_dp", 40'(dp), 40'd0);
        check("t6_rst_valid", 40'(frame_valid), 40'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 5; k < 8; k++) show(k, (k * 3) % 16, (k == 7), 10);
        check("t6_no_frame", 40'(n_stb), 40'd5);
        exp_q.push_back('{d: 32'h52FC9630, p: 8'h81});
        for (int k = 0; k < 5; k++) show(k, (k * 3) % 16, (k == 0), 10);
        drain("t6_drain");
        check("t6_stb_count", 40'(n_stb), 40'd6);
        check("final_errp_count", 40'(n_errp), 40'd1);
        check("final_erran_count", 40'(n_erran), 40'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
